// File: rtl/video_timing.sv
// Raster timing generator: free-running pixel/line counters with a one-cycle
// registered decode of sync, blank, data-enable, strobes and the prefetch line.
module video_timing #(
  parameter int H_ACTIVE = 720,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 32,
  parameter int H_BP     = 32,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 25
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [9:0] fetch_y,
  output logic       hsync,
  output logic       vsync,
  output logic       hblank,
  output logic       vblank,
  output logic       de,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG   = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_BEG   = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  // Counters are 10 bits wide, so neither raster dimension may exceed 1024.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
    $error("video_timing: H_TOTAL and V_TOTAL must both be <= 1024");
  end

  logic [9:0] hc, vc;
  logic       hsync_d, vsync_d, hblank_d, vblank_d, ls_d, fs_d;
  logic       h_wrap, v_wrap;
  logic [9:0] fetch_y_d;
  int         hc_i, vc_i;

  // Decode of the current counter position; registered below on ce.
  always_comb begin
    hc_i      = int'(hc);
    vc_i      = int'(vc);
    hsync_d   = (hc_i >= HS_BEG) && (hc_i < HS_END);
    vsync_d   = (vc_i >= VS_BEG) && (vc_i < VS_END);
    hblank_d  = hc_i >= H_ACTIVE;
    vblank_d  = vc_i >= V_ACTIVE;
    ls_d      = hc_i == H_ACTIVE;
    fs_d      = (hc == '0) && (vc == '0);
    h_wrap    = hc_i == H_TOTAL - 1;
    v_wrap    = vc_i == V_TOTAL - 1;
    // Line 0 is prefetched from the last active line through all of vblank.
    fetch_y_d = (vc_i < V_ACTIVE - 1) ? vc + 10'd1 : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge decode, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hc          <= '0;
      vc          <= '0;
      x           <= '0;
      y           <= '0;
      fetch_y     <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      hblank      <= 1'b0;
      vblank      <= 1'b0;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      x           <= hc;
      y           <= vc;
      fetch_y     <= fetch_y_d;
      hsync       <= hsync_d;
      vsync       <= vsync_d;
      hblank      <= hblank_d;
      vblank      <= vblank_d;
      de          <= ~hblank_d & ~vblank_d;
      line_start  <= ls_d;
      frame_start <= fs_d;
      if (h_wrap) begin
        hc <= '0;
        vc <= v_wrap ? '0 : vc + 10'd1;
      end else begin
        hc <= hc + 10'd1;
      end
    end else begin
      // Levels hold while stalled; strobes must not stretch.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing.sv
// Directed bench for video_timing: full-size instance for line-level timing,
// a scaled-down instance (32 x 17 raster) for frame-level timing.
module tb_video_timing;

  logic clk = 1'b0;
  logic reset_n;
  logic ce;

  int checks   = 0;
  int failures = 0;

  logic [9:0] d_x, d_y, d_fetch_y;
  logic       d_hsync, d_vsync, d_hblank, d_vblank, d_de, d_ls, d_fs;
  logic [9:0] s_x, s_y, s_fetch_y;
  logic       s_hsync, s_vsync, s_hblank, s_vblank, s_de, s_ls, s_fs;

  wire logic [37:0] d_all = {d_x, d_y, d_fetch_y, d_hsync, d_vsync, d_hblank,
                             d_vblank, d_de, d_ls, d_fs};
  wire logic [37:0] s_all = {s_x, s_y, s_fetch_y, s_hsync, s_vsync, s_hblank,
                             s_vblank, s_de, s_ls, s_fs};

  video_timing dut (
    .clk(clk), .reset_n(reset_n), .ce(ce),
    .x(d_x), .y(d_y), .fetch_y(d_fetch_y), .hsync(d_hsync), .vsync(d_vsync),
    .hblank(d_hblank), .vblank(d_vblank), .de(d_de),
    .line_start(d_ls), .frame_start(d_fs)
  );

  // H: 20 active, fp 4, sync 4 (24..27), bp 4 -> 32.  V: 10, fp 2, sync 3 (12..14), bp 2 -> 17.
  video_timing #(
    .H_ACTIVE(20), .H_FP(4), .H_SYNC(4), .H_BP(4),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2)
  ) dut_s (
    .clk(clk), .reset_n(reset_n), .ce(ce),
    .x(s_x), .y(s_y), .fetch_y(s_fetch_y), .hsync(s_hsync), .vsync(s_vsync),
    .hblank(s_hblank), .vblank(s_vblank), .de(s_de),
    .line_start(s_ls), .frame_start(s_fs)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_small_to(input int tx, input int ty, input string tag);
    int n = 0;
    while (!(int'(s_x) == tx && int'(s_y) == ty) && n < 2000) begin
      step();
      n++;
    end
    check(tag, 64'(int'(s_x) == tx && int'(s_y) == ty), 64'd1);
  endtask

  initial begin
    int hs_first = -1, hs_last = -1, hs_cnt = 0, ls_cnt = 0, ls_x = -1, hb_first = -1;
    int last_x = -1, last_y = -1, period = 0;

    reset_n = 1'b0;
    ce      = 1'b0;
    #22;
    check("reset_zero_d", 64'(d_all), 64'd0);
    check("reset_zero_s", 64'(s_all), 64'd0);

    // Release between edges; the next edge is the first ce cycle.
    step();
    reset_n = 1'b1;
    ce      = 1'b1;

    for (int i = 0; i < 800; i++) begin
      step();
      if (i == 0) begin
        check("first_x", 64'(d_x), 64'd0);
        check("first_y", 64'(d_y), 64'd0);
        check("first_de", 64'(d_de), 64'd1);
        check("first_fs", 64'(d_fs), 64'd1);
        check("first_hblank", 64'(d_hblank), 64'd0);
        check("first_fetch_y", 64'(d_fetch_y), 64'd1);
      end
      if (i == 1) check("fs_one_clk", 64'(d_fs), 64'd0);
      if (d_hsync) begin
        if (hs_cnt == 0) hs_first = int'(d_x);
        hs_last = int'(d_x);
        hs_cnt++;
      end
      if (d_ls) begin
        ls_cnt++;
        ls_x = int'(d_x);
      end
      if (d_hblank && hb_first < 0) hb_first = int'(d_x);
      last_x = int'(d_x);
      last_y = int'(d_y);
      if (i == 720) begin
        check("x720_de", 64'(d_de), 64'd0);
        ce = 1'b0;
        step();
        check("stall_ls_clear", 64'(d_ls), 64'd0);
        check("stall_hblank_hold", 64'(d_hblank), 64'd1);
        check("stall_x_hold", 64'(d_x), 64'd720);
        ce = 1'b1;
      end
    end
    check("hsync_first", 64'(hs_first), 64'd736);
    check("hsync_last", 64'(hs_last), 64'd767);
    check("hsync_width", 64'(hs_cnt), 64'd32);
    check("line_start_count", 64'(ls_cnt), 64'd1);
    check("line_start_x", 64'(ls_x), 64'd720);
    check("hblank_rise_x", 64'(hb_first), 64'd720);
    check("line_end_x", 64'(last_x), 64'd799);
    check("line_end_y", 64'(last_y), 64'd0);
    step();
    check("wrap_x", 64'(d_x), 64'd0);
    check("wrap_y", 64'(d_y), 64'd1);
    check("wrap_fetch_y", 64'(d_fetch_y), 64'd2);
    check("wrap_hblank", 64'(d_hblank), 64'd0);

    // Asynchronous reset: outputs clear with no clock edge.
    reset_n = 1'b0;
    ce      = 1'b0;
    #1;
    check("async_reset_d", 64'(d_all), 64'd0);
    step();
    step();
    reset_n = 1'b1;

    // ce pattern 1,0,1,0.
    ce = 1'b1; step();
    check("tog1_x", 64'(d_x), 64'd0);
    check("tog1_fs", 64'(d_fs), 64'd1);
    ce = 1'b0; step();
    check("tog0_x", 64'(d_x), 64'd0);
    check("tog0_fs", 64'(d_fs), 64'd0);
    check("tog0_de", 64'(d_de), 64'd1);
    ce = 1'b1; step();
    check("tog1b_x", 64'(d_x), 64'd1);
    ce = 1'b0; step();
    check("tog0b_x", 64'(d_x), 64'd1);
    check("tog0b_fs", 64'(d_fs), 64'd0);
    ce = 1'b1;

    // Frame-level behaviour on the scaled instance.
    run_small_to(0, 8, "reach_y8");
    check("s_fetch_y8", 64'(s_fetch_y), 64'd9);
    check("s_vblank_y8", 64'(s_vblank), 64'd0);
    run_small_to(0, 9, "reach_y9");
    check("s_fetch_y9", 64'(s_fetch_y), 64'd0);
    check("s_vblank_y9", 64'(s_vblank), 64'd0);
    run_small_to(0, 10, "reach_y10");
    check("s_vblank_y10", 64'(s_vblank), 64'd1);
    check("s_de_y10", 64'(s_de), 64'd0);
    run_small_to(31, 11, "reach_y11");
    check("s_vsync_y11", 64'(s_vsync), 64'd0);
    run_small_to(0, 12, "reach_y12");
    check("s_vsync_y12", 64'(s_vsync), 64'd1);
    check("s_fetch_y12", 64'(s_fetch_y), 64'd0);
    run_small_to(20, 13, "reach_ls_vblank");
    check("s_ls_vblank_line", 64'(s_ls), 64'd1);
    run_small_to(31, 14, "reach_y14");
    check("s_vsync_y14", 64'(s_vsync), 64'd1);
    run_small_to(0, 15, "reach_y15");
    check("s_vsync_y15", 64'(s_vsync), 64'd0);
    run_small_to(31, 16, "reach_last");
    check("s_fetch_last", 64'(s_fetch_y), 64'd0);
    check("s_vblank_last", 64'(s_vblank), 64'd1);
    step();
    check("s_fwrap_pos", 64'({s_x, s_y}), 64'd0);
    check("s_fwrap_fs", 64'(s_fs), 64'd1);
    check("s_fwrap_vblank", 64'(s_vblank), 64'd0);
    check("s_fwrap_ls", 64'(s_ls), 64'd0);

    // Frame period with ce held high: 32 * 17 = 544 clocks.
    do begin
      step();
      period++;
    end while (!s_fs && period < 2000);
    check("s_frame_period", 64'(period), 64'd544);

    // Mid-line reset, then restart at (0,0).
    run_small_to(10, 5, "reach_mid");
    reset_n = 1'b0;
    #1;
    check("mid_reset_s", 64'(s_all), 64'd0);
    check("mid_reset_d", 64'(d_all), 64'd0);
    step();
    reset_n = 1'b1;
    step();
    check("restart_s_pos", 64'({s_x, s_y}), 64'd0);
    check("restart_s_fs", 64'(s_fs), 64'd1);
    check("restart_s_ls", 64'(s_ls), 64'd0);
    check("restart_d_fs", 64'(d_fs), 64'd1);
    step();
    check("restart_s_x1", 64'(s_x), 64'd1);
    check("restart_s_fs_clear", 64'(s_fs), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
